// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register-access controller.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_BUS,
    S_WAIT_RDUMMY,
    S_WAIT_WDATA,
    S_WR_BUS
  } state_t;

  typedef struct packed {
    logic       rd;
    logic [6:0] addr;
  } cmd_t;

  localparam int CMD_RD_BIT = 7;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c.rd   = b[CMD_RD_BIT];
    c.addr = b[6:0];
    return c;
  endfunction

  function automatic logic [7:0] status_byte(input logic [4:0] id_hi, input logic proto,
                                             input logic bus, input logic timeout);
    return {id_hi, proto, bus, timeout};
  endfunction

endpackage

// File: rtl/spi_timeout_cnt.sv
// Wait-state watchdog: down-counter reloaded on clear, expired at terminal count.
module spi_timeout_cnt #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TC_LOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= TC_LOAD;
    end else if (clear) begin
      cnt <= TC_LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command/register-access controller: decodes command frames, runs register bus
// cycles and keeps the slave transmit byte loaded with read data or a status byte.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 4096,
  parameter logic [7:0] STATUS_ID   = 8'hA0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Clk_en,
  input  logic [7:0] i_rx_byte,
  input  logic       i_byte_ready,
  input  logic       i_spi_busy,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_ready,
  output logic       o_reg_req,
  output logic       o_reg_wr,
  output logic [6:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic       i_reg_ack,
  input  logic [7:0] i_reg_rdata,
  input  logic       i_err_clr,
  output logic       o_err_timeout,
  output logic       o_err_bus,
  output logic       o_err_proto,
  output logic       o_idle
);

  state_t     state, state_nxt;
  cmd_t       cmd;
  logic       expired;
  logic       in_bus, in_wait;
  logic       err_to_set, err_bus_set, err_proto_set;
  logic       err_to_nxt, err_bus_nxt, err_proto_nxt;
  logic       rd_done, idle_entry, load_new, tx_pending, boot_load;
  logic [7:0] tx_src;

  assign cmd     = decode_cmd(i_rx_byte);
  assign in_bus  = (state == S_RD_BUS) || (state == S_WR_BUS);
  assign in_wait = in_bus || (state == S_WAIT_RDUMMY) || (state == S_WAIT_WDATA);

  spi_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .clear   (i_Clk_en && ((state_nxt != state) || i_byte_ready)),
    .enable  (i_Clk_en && in_wait),
    .expired (expired)
  );

  always_comb begin
    state_nxt     = state;
    err_to_set    = 1'b0;
    err_bus_set   = 1'b0;
    err_proto_set = 1'b0;
    rd_done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_byte_ready) state_nxt = cmd.rd ? S_RD_BUS : S_WAIT_WDATA;
      end
      S_RD_BUS: begin
        err_proto_set = i_byte_ready;
        if (i_reg_ack) begin
          rd_done   = 1'b1;
          state_nxt = S_WAIT_RDUMMY;
        end else if (expired) begin
          err_bus_set = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_WAIT_RDUMMY: begin
        if (i_byte_ready) begin
          state_nxt = S_IDLE;
        end else if (expired) begin
          err_to_set = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_WAIT_WDATA: begin
        if (i_byte_ready) begin
          state_nxt = S_WR_BUS;
        end else if (expired) begin
          err_to_set = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_WR_BUS: begin
        err_proto_set = i_byte_ready;
        if (i_reg_ack) begin
          state_nxt = S_IDLE;
        end else if (expired) begin
          err_bus_set = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Set beats clear; the status byte captures flags as they will be after this edge.
  assign err_to_nxt    = err_to_set    | (o_err_timeout & ~i_err_clr);
  assign err_bus_nxt   = err_bus_set   | (o_err_bus     & ~i_err_clr);
  assign err_proto_nxt = err_proto_set | (o_err_proto   & ~i_err_clr);

  assign idle_entry = (state_nxt == S_IDLE) && (state != S_IDLE);
  assign load_new   = idle_entry || rd_done || boot_load;
  assign tx_src     = rd_done ? i_reg_rdata
                              : status_byte(STATUS_ID[7:3], err_proto_nxt, err_bus_nxt, err_to_nxt);

  // Request drops in the expiry cycle itself unless ack arrives alongside it.
  assign o_reg_req = in_bus && (i_reg_ack || !expired);
  assign o_reg_wr  = (state == S_WR_BUS);
  assign o_idle    = (state == S_IDLE);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else if (i_Clk_en) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_reg_addr    <= '0;
      o_reg_wdata   <= '0;
      o_tx_byte     <= '0;
      o_tx_ready    <= 1'b0;
      tx_pending    <= 1'b1;
      boot_load     <= 1'b1;
      o_err_timeout <= 1'b0;
      o_err_bus     <= 1'b0;
      o_err_proto   <= 1'b0;
    end else if (i_Clk_en) begin
      boot_load     <= 1'b0;
      o_err_timeout <= err_to_nxt;
      o_err_bus     <= err_bus_nxt;
      o_err_proto   <= err_proto_nxt;
      if ((state == S_IDLE) && i_byte_ready) o_reg_addr <= cmd.addr;
      if ((state == S_WAIT_WDATA) && i_byte_ready) o_reg_wdata <= i_rx_byte;
      if (load_new) o_tx_byte <= tx_src;
      // The slave only takes a load between frames, so a pending load waits for busy to fall.
      o_tx_ready <= (tx_pending || load_new) && !i_spi_busy;
      tx_pending <= (tx_pending || load_new) && i_spi_busy;
    end
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register-access controller that sits behind spiSlave (8-bit, one byte per slave-select frame).
- Decodes command bytes received over SPI and runs reads/writes on a simple register bus.
- Preloads the slave's transmit byte with read data or a status byte.
- Sequences the slave datapath frame by frame and recovers from aborted or stalled transactions.

Parameters:
- TIMEOUT_CYC, 4096: enabled-clock cycles allowed in any wait state before abort; must be ≥ 4.
- STATUS_ID, 8'hA0: upper 5 bits form the idle status byte; bits [2:0] are ignored.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  reset; one clock, reset asynchronous active-low.
- i_Clk_en  in  1  clock enable; state advances only when 1.
- i_rx_byte  in  8  received byte from slave (valid with i_byte_ready).
- i_byte_ready  in  1  one-cycle pulse: frame ended, i_rx_byte valid.
- i_spi_busy  in  1  slave frame in progress (slave-select active).
- o_tx_byte  out  8  byte to load into slave transmit register.
- o_tx_ready  out  1  load strobe to slave.
- o_reg_req  out  1  register bus request; held until ack.
- o_reg_wr  out  1  1 = write, 0 = read; valid with o_reg_req.
- o_reg_addr  out  7  register address.
- o_reg_wdata  out  8  write data.
- i_reg_ack  in  1  bus completion; rdata valid same cycle for reads.
- i_reg_rdata  in  8  read data.
- i_err_clr  in  1  clears sticky error flags.
- o_err_timeout  out  1  sticky: SPI frame wait timed out.
- o_err_bus  out  1  sticky: register bus ack timed out.
- o_err_proto  out  1  sticky: byte arrived while bus access pending.
- o_idle  out  1  FSM in S_IDLE.

Behaviour:
- Reset (async): FSM → S_IDLE; all outputs 0, except o_idle = 1; internal tx_pending = 1.
- All sequential logic is qualified by i_Clk_en; when it is 0, state and outputs hold.
- Command byte: bit7 = 1 read, 0 write; bits[6:0] = address.
- Status byte: {STATUS_ID[7:3], o_err_proto, o_err_bus, o_err_timeout}.
- tx load rule: o_tx_ready = tx_pending && !i_spi_busy, for exactly one enabled cycle; that cycle clears tx_pending.
  - The slave only accepts loads between frames, so a pending load waits until i_spi_busy falls.
  - o_tx_byte is stable from the cycle tx_pending is set until the next set.
- S_IDLE: on entry, o_tx_byte ← status byte and tx_pending ← 1. On i_byte_ready, latch addr:
  - read → S_RD_BUS.
  - write → S_WAIT_WDATA.
- S_RD_BUS: o_reg_req = 1, o_reg_wr = 0 until i_reg_ack. On ack: o_tx_byte ← i_reg_rdata, tx_pending ← 1, → S_WAIT_RDUMMY. Request drops the cycle after ack.
- S_WAIT_RDUMMY: the master clocks a dummy frame, during which the slave shifts out the read data. On i_byte_ready, discard the byte → S_IDLE.
- S_WAIT_WDATA: on i_byte_ready, latch o_reg_wdata → S_WR_BUS.
- S_WR_BUS: o_reg_req = 1, o_reg_wr = 1 until i_reg_ack → S_IDLE.
- Read latency: read data is loaded within (bus latency + 2) enabled cycles after the command i_byte_ready. The master must hold slave-select inactive at least that long.
- Timeout counter: resets on every state entry and on i_byte_ready; increments each enabled cycle in the four wait states. Reaching TIMEOUT_CYC−1 causes:
  - in S_WAIT_WDATA / S_WAIT_RDUMMY: o_err_timeout ← 1, → S_IDLE.
  - in S_RD_BUS / S_WR_BUS: o_err_bus ← 1, o_reg_req drops the same cycle, → S_IDLE.
- i_byte_ready in S_RD_BUS / S_WR_BUS: byte discarded, o_err_proto ← 1; the bus access completes normally.
- i_err_clr and a new error in the same cycle: set wins.
- The status byte reflects flag values at the moment of S_IDLE entry.
- Timeout and i_reg_ack in the same cycle: ack wins, no error.
- Async reset mid-transaction: o_reg_req drops immediately and no partial write is issued. The next command starts clean.

Decomposition:
- Package spi_reg_pkg contains:
  - state enum {S_IDLE, S_RD_BUS, S_WAIT_RDUMMY, S_WAIT_WDATA, S_WR_BUS}.
  - packed struct cmd_t {rd, addr[6:0]}.
  - constant CMD_RD_BIT = 7.
- Sub-module spi_timeout_cnt, parameterised by TIMEOUT_CYC, with inputs clear and enable and output expired.

Test Plan:
- Write: frame 8'h05, then frame 8'h3C, ack after 3 cycles → one request with wr=1, addr=7'h05, wdata=8'h3C; FSM returns to S_IDLE; tx reloads status 8'hA0.
- Read: frame 8'h85, rdata 8'h5A with ack after 2 cycles → o_tx_ready pulses with o_tx_byte=8'h5A before the next frame; the dummy frame MISO shifts 8'h5A; FSM returns to S_IDLE.
- Frame timeout: write command with no data frame, TIMEOUT_CYC=16 → S_IDLE after 16 cycles, o_err_timeout=1, status byte 8'hA1; i_err_clr restores status 8'hA0.
- Bus timeout: read with i_reg_ack never asserted → o_reg_req drops, o_err_bus=1, no tx load of read data.
- Protocol and gating: i_byte_ready during S_WR_BUS → o_err_proto=1 and the write still completes. tx load requested while i_spi_busy=1 → o_tx_ready is withheld until busy falls. i_Clk_en=0 for 5 cycles → state frozen.
- Async reset asserted in S_RD_BUS → o_reg_req=0 immediately; after release, o_idle=1 and a status load is pulsed.
